instruction_fetch_unit: RTL and testbench

//  PC register and IF/ID boundary of the MIPS core. Drives the Program_Memory word address, computes the

---
 rtl/mips_fetch_pkg.sv | 17 +
 rtl/next_pc_mux.sv | 68 ++++++
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared constants for the MIPS fetch stage: reset vector, NOP encoding,
// word size and the next-PC source select encoding.
package mips_fetch_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
    localparam int unsigned WORD_BYTES           = 4;

    // Source of the next PC, in increasing priority order.
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_JR     = 2'd3
    } next_pc_sel_e;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC computation for the fetch stage: builds the sequential, branch,
// jump and jr candidates, picks one by priority (jr > jump > branch > seq)
// and flags a target that is outside program memory or not word aligned.
// Redirects are only considered while the IF/ID register holds a live
// instruction, because the ID stage is the one resolving them.
module next_pc_mux
    import mips_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int                    MEMORY_DEPTH = 32
) (
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] if_id_pc_plus4,
    input  logic                  if_id_valid,
    input  logic                  branch_taken,
    input  logic [15:0]           branch_offset,
    input  logic                  jump,
    input  logic [25:0]           jump_target,
    input  logic                  jr,
    input  logic [DATA_WIDTH-1:0] jr_address,
    output logic [DATA_WIDTH-1:0] next_pc,
    output next_pc_sel_e          sel,
    output logic                  redirect,
    output logic                  out_of_range
);

    localparam logic [DATA_WIDTH-1:0] WORD_STEP = DATA_WIDTH'(WORD_BYTES);
    localparam logic [DATA_WIDTH-1:0] LAST_PC   =
        RESET_VECTOR + DATA_WIDTH'(WORD_BYTES * unsigned'(MEMORY_DEPTH - 1));

    logic [DATA_WIDTH-1:0] seq_target;
    logic [DATA_WIDTH-1:0] branch_target;
    logic [DATA_WIDTH-1:0] jump_target_full;

    // Candidate targets; all arithmetic wraps modulo 2^DATA_WIDTH.
    always_comb begin
        seq_target       = pc + WORD_STEP;
        branch_target    = if_id_pc_plus4 +
                           {{(DATA_WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
        jump_target_full = {if_id_pc_plus4[DATA_WIDTH-1 -: 4], jump_target, 2'b00};
    end

    // Priority select and legality check of the chosen target.
    always_comb begin
        sel = SEL_SEQ;
        if (if_id_valid) begin
            if (jr)
                sel = SEL_JR;
            else if (jump)
                sel = SEL_JUMP;
            else if (branch_taken)
                sel = SEL_BRANCH;
        end

        case (sel)
            SEL_JR:     next_pc = jr_address;
            SEL_JUMP:   next_pc = jump_target_full;
            SEL_BRANCH: next_pc = branch_target;
            default:    next_pc = seq_target;
        endcase

        redirect     = (sel != SEL_SEQ);
        out_of_range = (next_pc < RESET_VECTOR) || (next_pc > LAST_PC) ||
                       (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC register and IF/ID pipeline boundary of the MIPS core.
// Holds the PC, latches the fetched instruction with its PC+4 and a valid
// bit, applies stall and redirect, and keeps a sticky fetch fault.
// Optional feature macro: BRANCH_DELAY_SLOT_EN -- when defined, an accepted
// redirect keeps the instruction fetched that cycle (the delay slot) instead
// of flushing it.
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int                    MEMORY_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  branch_taken_i,
    input  logic [15:0]           branch_offset_i,
    input  logic                  jump_i,
    input  logic [25:0]           jump_target_i,
    input  logic                  jr_i,
    input  logic [DATA_WIDTH-1:0] jr_address_i,
    input  logic [DATA_WIDTH-1:0] instruction_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] if_id_instruction_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
    output logic                  if_id_valid_o,
    output logic                  fetch_fault_o
);

    localparam logic [DATA_WIDTH-1:0] WORD_STEP = DATA_WIDTH'(WORD_BYTES);

    logic [DATA_WIDTH-1:0] next_pc;
    next_pc_sel_e          next_sel;
    logic                  redirect;
    logic                  out_of_range;

    next_pc_mux #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VECTOR(RESET_VECTOR),
        .MEMORY_DEPTH(MEMORY_DEPTH)
    ) u_next_pc_mux (
        .pc            (pc_o),
        .if_id_pc_plus4(if_id_pc_plus4_o),
        .if_id_valid   (if_id_valid_o),
        .branch_taken  (branch_taken_i),
        .branch_offset (branch_offset_i),
        .jump          (jump_i),
        .jump_target   (jump_target_i),
        .jr            (jr_i),
        .jr_address    (jr_address_i),
        .next_pc       (next_pc),
        .sel           (next_sel),
        .redirect      (redirect),
        .out_of_range  (out_of_range)
    );

    // PC, IF/ID and sticky fault. Once faulted the PC freezes at its last
    // legal value and IF/ID carries only bubbles until reset; the edge that
    // detects the fault already inserts a bubble. A stall freezes everything
    // and can never raise the fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_o                <= RESET_VECTOR;
            if_id_instruction_o <= NOP_INSTR;
            if_id_pc_plus4_o    <= '0;
            if_id_valid_o       <= 1'b0;
            fetch_fault_o       <= 1'b0;
        end else if (fetch_fault_o) begin
            if_id_instruction_o <= NOP_INSTR;
            if_id_pc_plus4_o    <= '0;
            if_id_valid_o       <= 1'b0;
        end else if (!stall_i) begin
            if (out_of_range) begin
                fetch_fault_o       <= 1'b1;
                if_id_instruction_o <= NOP_INSTR;
                if_id_pc_plus4_o    <= '0;
                if_id_valid_o       <= 1'b0;
            end else begin
                pc_o <= next_pc;
`ifdef BRANCH_DELAY_SLOT_EN
                // The word fetched alongside the redirect is the delay slot
                // and always executes.
                if_id_instruction_o <= instruction_i;
                if_id_pc_plus4_o    <= pc_o + WORD_STEP;
                if_id_valid_o       <= 1'b1;
`else
                if (redirect) begin
                    if_id_instruction_o <= NOP_INSTR;
                    if_id_pc_plus4_o    <= '0;
                    if_id_valid_o       <= 1'b0;
                end else begin
                    if_id_instruction_o <= instruction_i;
                    if_id_pc_plus4_o    <= pc_o + WORD_STEP;
                    if_id_valid_o       <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by randomized stall/redirect traffic, checked against a reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RV    = 32'h0040_0000;
    localparam int          DEPTH = 32;
    localparam logic [31:0] LAST  = RV + 32'(4 * (DEPTH - 1));

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // DUT signals
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [15:0] branch_offset_i = '0;
    logic        jump_i = 1'b0;
    logic [25:0] jump_target_i = '0;
    logic        jr_i = 1'b0;
    logic [31:0] jr_address_i = '0;
    logic [31:0] instruction_i;
    logic [31:0] pc_o;
    logic [31:0] if_id_instruction_o;
    logic [31:0] if_id_pc_plus4_o;
    logic        if_id_valid_o;
    logic        fetch_fault_o;

    instruction_fetch_unit dut (
        .clk                (clk),
        .reset              (reset),
        .stall_i            (stall_i),
        .branch_taken_i     (branch_taken_i),
        .branch_offset_i    (branch_offset_i),
        .jump_i             (jump_i),
        .jump_target_i      (jump_target_i),
        .jr_i               (jr_i),
        .jr_address_i       (jr_address_i),
        .instruction_i      (instruction_i),
        .pc_o               (pc_o),
        .if_id_instruction_o(if_id_instruction_o),
        .if_id_pc_plus4_o   (if_id_pc_plus4_o),
        .if_id_valid_o      (if_id_valid_o),
        .fetch_fault_o      (fetch_fault_o)
    );

    // program memory model
    logic [31:0] mem [0:DEPTH-1];
    int          mem_gen = 0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        int idx;
        if (a >= RV && a <= LAST && a[1:0] == 2'b00) begin
            idx = int'((a - RV) / 4);
            return mem[idx];
        end
        return 32'hDEAD_BEEF;
    endfunction

    always @(pc_o, mem_gen) instruction_i = mem_read(pc_o);

    // bookkeeping
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: architectural state of the fetch stage
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_valid, m_fault;

    // expected queue: {pc, instr, pc_plus4, valid, fault}
    logic [97:0] exp_q[$];

    task automatic model_reset();
        m_pc    = RV;
        m_instr = 32'h0;
        m_p4    = 32'h0;
        m_valid = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        logic [31:0] fetched;
        logic        take;
        logic        legal;
        if (m_fault) begin
            m_valid = 1'b0; m_instr = 32'h0; m_p4 = 32'h0;
        end else if (!stall_i) begin
            take = m_valid && (jr_i || jump_i || branch_taken_i);
            if (!take)              tgt = m_pc + 32'd4;
            else if (jr_i)          tgt = jr_address_i;
            else if (jump_i)        tgt = {m_p4[31:28], jump_target_i, 2'b00};
            else                    tgt = m_p4 + 32'(int'($signed(branch_offset_i)) * 4);
            legal   = (tgt >= RV) && (tgt <= LAST) && (tgt % 4 == 0);
            fetched = mem_read(m_pc);
            if (!legal) begin
                m_fault = 1'b1;
                m_valid = 1'b0; m_instr = 32'h0; m_p4 = 32'h0;
            end else begin
`ifdef BRANCH_DELAY_SLOT_EN
                m_instr = fetched; m_p4 = m_pc + 32'd4; m_valid = 1'b1;
`else
                if (take) begin
                    m_instr = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
                end else begin
                    m_instr = fetched; m_p4 = m_pc + 32'd4; m_valid = 1'b1;
                end
`endif
                m_pc = tgt;
            end
        end
    endtask

    // driver: called at a falling edge; applies inputs, predicts the next
    // rising edge, and returns at the following falling edge
    task automatic drive(input logic st, input logic br, input logic [15:0] off,
                         input logic j, input logic [25:0] jt,
                         input logic r, input logic [31:0] ra);
        stall_i = st; branch_taken_i = br; branch_offset_i = off;
        jump_i = j; jump_target_i = jt; jr_i = r; jr_address_i = ra;
        model_step();
        exp_q.push_back({m_pc, m_instr, m_p4, m_valid, m_fault});
        @(negedge clk);
    endtask

    task automatic drive_seq();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    // asynchronous reset mid-cycle, checked before any clock edge
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_pc", pc_o, RV);
        chk("rst_instr", if_id_instruction_o, 32'h0);
        chk("rst_p4", if_id_pc_plus4_o, 32'h0);
        chk("rst_valid", 32'(if_id_valid_o), 32'h0);
        chk("rst_fault", 32'(fetch_fault_o), 32'h0);
        model_reset();
        stall_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0; jr_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // monitor / scoreboard
    initial begin
        logic [97:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc_o, e[97:66]);
                chk("instr", if_id_instruction_o, e[65:34]);
                chk("pc_plus4", if_id_pc_plus4_o, e[33:2]);
                chk("valid", 32'(if_id_valid_o), 32'(e[1]));
                chk("fault", 32'(fetch_fault_o), 32'(e[0]));
            end
        end
    end

    // stimulus
    initial begin
        int guard;
        logic        st, br, j, r;
        logic [15:0] off;
        logic [25:0] jt;
        logic [31:0] ra;
        int          kind;

        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
        mem_gen++;
        model_reset();
        do_reset();

        // sequential fetch from reset vector
        drive_seq();
        drive_seq();
        chk("t1_pc", pc_o, 32'h0040_0008);
        chk("t1_instr", if_id_instruction_o, 32'h1);
        chk("t1_valid", 32'(if_id_valid_o), 32'h1);

        // three stalled edges, then resume
        repeat (3) drive(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("t2_pc_held", pc_o, 32'h0040_0008);
        chk("t2_instr_held", if_id_instruction_o, 32'h1);
        drive_seq();
        chk("t2_pc_resume", pc_o, 32'h0040_000C);

        // backward branch from if_id_pc_plus4 = 0x400010
        drive_seq();
        chk("t3_p4", if_id_pc_plus4_o, 32'h0040_0010);
        drive(1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("t3_pc", pc_o, 32'h0040_0008);
`ifdef BRANCH_DELAY_SLOT_EN
        chk("t3_valid", 32'(if_id_valid_o), 32'h1);
`else
        chk("t3_valid", 32'(if_id_valid_o), 32'h0);
`endif

        // jump and jr together: jr wins
        drive_seq();
        drive(1'b0, 1'b1, 16'h0010, 1'b1, 26'h10_0010, 1'b1, 32'h0040_0004);
        chk("t4_pc", pc_o, 32'h0040_0004);

        // misaligned jr: sticky fault, PC frozen at last legal value
        drive_seq();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0040_0002);
        chk("t5_fault", 32'(fetch_fault_o), 32'h1);
        chk("t5_pc", pc_o, 32'h0040_0008);
        for (int i = 0; i < 4; i++)
            drive(1'(i[0]), 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("t5_fault_sticky", 32'(fetch_fault_o), 32'h1);
        chk("t5_valid", 32'(if_id_valid_o), 32'h0);
        do_reset();

        // run off the end of program memory; a stall at the boundary never faults
        repeat (31) drive_seq();
        chk("t6_pc_last", pc_o, 32'h0040_007C);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("t6_no_fault_stalled", 32'(fetch_fault_o), 32'h0);
        drive_seq();
        chk("t6_fault", 32'(fetch_fault_o), 32'h1);
        chk("t6_pc_hold", pc_o, 32'h0040_007C);

        // bounded wait: reach a given PC through plain fetches
        do_reset();
        guard = 0;
        while (m_pc != 32'h0040_0040 && guard < 64) begin
            drive_seq();
            guard++;
        end
        checks++;
        if (guard >= 64) begin
            errors++;
            $display("FAIL wait_pc: model pc 0x%08h never reached 0x00400040", m_pc);
        end

        // randomized traffic on random memory contents
        do_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem_gen++;
        for (int n = 0; n < 2000; n++) begin
            st   = ($urandom_range(0, 3) == 0);
            kind = $urandom_range(0, 9);
            br   = (kind <= 1) || (kind == 4);
            j    = (kind == 2) || (kind == 4);
            r    = (kind == 3) || (kind == 4);
            off  = 16'($signed($urandom_range(0, 24)) - 12);
            jt   = 26'h10_0000 + 26'($urandom_range(0, DEPTH));
            ra   = RV + 32'(4 * $urandom_range(0, DEPTH));
            if ($urandom_range(0, 15) == 0) ra = ra + 32'd2;
            drive(st, br, off, j, jt, r, ra);
            if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
                do_reset();
        end

        // drain the scoreboard
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
